adc_boxcar_decim: RTL and testbench

Two-stage boxcar decimator for the radar receive path. It accumulates signed ADC samples on the fast clock and emits a 16:1 average once per `clk_div_16` period and a 32:1 average once per `clk_div_32` period. The 32:1 output has a valid/ready handshake toward the sample buffer. Window boundaries come from the rising edges of the divided clocks, which are used as enables; the block never clocks on them.

---
 rtl/adc_boxcar_decim_pkg.sv | 12 +
 rtl/boxcar_acc.sv | 57 +++++
 rtl/adc_boxcar_decim.sv | 115 +++++++++++
 tb/tb_adc_boxcar_decim.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_boxcar_decim_pkg.sv
// Shared constants and types for the two-stage boxcar decimator.
package adc_boxcar_decim_pkg;

  localparam int unsigned DECIM16_LOG2 = 4;

  typedef enum logic [1:0] {StPrime, StFirst, StSecond} pair_state_e;

  function automatic int unsigned acc_width(int unsigned data_w);
    return data_w + DECIM16_LOG2;
  endfunction

endpackage

// File: rtl/boxcar_acc.sv
// Edge-gated 16:1 boxcar accumulator with saturating sample count and sticky underrun.
// DECIM_ROUND_EN selects round-half-up instead of floor for the window average.
module boxcar_acc
  import adc_boxcar_decim_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              close,
  input  logic              check,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] result,
  output logic              underrun
);

  localparam int unsigned AccW = acc_width(DATA_W);
  localparam logic [DECIM16_LOG2:0] CntFull = {1'b1, {DECIM16_LOG2{1'b0}}};

  logic signed [AccW-1:0] sum_q;
  logic signed [AccW-1:0] sample_ext;
  logic [DECIM16_LOG2:0]  cnt_q;

  assign sample_ext = {{DECIM16_LOG2{adc_data[DATA_W-1]}}, adc_data};

`ifdef DECIM_ROUND_EN
  // One guard bit so the rounding add cannot wrap before the shift.
  logic signed [AccW:0] sum_rnd;
  logic                 unused_rnd;
  assign sum_rnd    = {sum_q[AccW-1], sum_q} + {{(AccW-DECIM16_LOG2+1){1'b0}}, 1'b1,
                                                {(DECIM16_LOG2-1){1'b0}}};
  assign result     = sum_rnd[AccW-1:DECIM16_LOG2];
  assign unused_rnd = ^{sum_rnd[AccW], sum_rnd[DECIM16_LOG2-1:0]};
`else
  logic unused_low;
  assign result     = sum_q[AccW-1:DECIM16_LOG2];
  assign unused_low = ^sum_q[DECIM16_LOG2-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      cnt_q    <= '0;
      underrun <= 1'b0;
    end else if (close) begin
      // A sample arriving with the edge seeds the next window.
      sum_q <= adc_valid ? sample_ext : '0;
      cnt_q <= {{DECIM16_LOG2{1'b0}}, adc_valid};
      if (check && (cnt_q < CntFull)) underrun <= 1'b1;
    end else if (adc_valid) begin
      sum_q <= sum_q + sample_ext;
      if (cnt_q < CntFull) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_boxcar_decim.sv
// Two-stage boxcar decimator: 16:1 window average and 32:1 pair average with handshake.
// DECIM_ROUND_EN selects round-half-up in both stages; default is floor.
module adc_boxcar_decim
  import adc_boxcar_decim_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_div_16,
  input  logic              clk_div_32,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] dec16_data,
  output logic              dec16_valid,
  output logic [DATA_W-1:0] dec32_data,
  output logic              dec32_valid,
  input  logic              dec32_ready,
  output logic              underrun,
  output logic              overflow
);

  logic              prev16_q, prev32_q;
  logic              e16, e32, emit;
  pair_state_e       state_q;
  logic [DATA_W-1:0] half_a_q, half_b_q, win_result;
  logic              pair_pend_q;
  logic [DATA_W:0]   pair_sum;
  logic [DATA_W-1:0] pair_avg;
  logic              unused_pair_lsb;

  assign e16 = clk_div_16 & ~prev16_q;
  assign e32 = clk_div_32 & ~prev32_q;

  // Only closes that complete a real pair slot produce output or count toward underrun.
  assign emit = e16 & (((state_q == StFirst) & ~e32) | (state_q == StSecond));

`ifdef DECIM_ROUND_EN
  assign pair_sum = {half_a_q[DATA_W-1], half_a_q} + {half_b_q[DATA_W-1], half_b_q}
                    + {{DATA_W{1'b0}}, 1'b1};
`else
  assign pair_sum = {half_a_q[DATA_W-1], half_a_q} + {half_b_q[DATA_W-1], half_b_q};
`endif
  assign pair_avg        = pair_sum[DATA_W:1];
  assign unused_pair_lsb = pair_sum[0];

  boxcar_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .close     (e16),
    .check     (emit),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .result    (win_result),
    .underrun  (underrun)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev16_q    <= 1'b1;
      prev32_q    <= 1'b1;
      state_q     <= StPrime;
      half_a_q    <= '0;
      half_b_q    <= '0;
      pair_pend_q <= 1'b0;
      dec16_data  <= '0;
      dec16_valid <= 1'b0;
      dec32_data  <= '0;
      dec32_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev16_q    <= clk_div_16;
      prev32_q    <= clk_div_32;
      dec16_valid <= emit;
      if (emit) dec16_data <= win_result;
      pair_pend_q <= 1'b0;

      if (e16) begin
        unique case (state_q)
          StPrime: if (e32) state_q <= StFirst;
          StFirst: begin
            // e32 here means phase was lost: discard and wait for the next half A.
            if (!e32) begin
              half_a_q <= win_result;
              state_q  <= StSecond;
            end
          end
          StSecond: begin
            if (e32) begin
              half_b_q    <= win_result;
              pair_pend_q <= 1'b1;
              state_q     <= StFirst;
            end else begin
              half_a_q <= win_result;
            end
          end
          default: state_q <= StPrime;
        endcase
      end

      if (dec32_valid && dec32_ready) dec32_valid <= 1'b0;
      if (pair_pend_q) begin
        if (!dec32_valid || dec32_ready) begin
          dec32_data  <= pair_avg;
          dec32_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_boxcar_decim.sv
// Scoreboard bench for adc_boxcar_decim against an arithmetic window/pair model.
module tb_adc_boxcar_decim;

  localparam int unsigned DATA_W = 12;
`ifdef DECIM_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, clk_div_16, clk_div_32, adc_valid, dec32_ready;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] dec16_data, dec32_data;
  logic              dec16_valid, dec32_valid, underrun, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int exp16_q[$];
  int exp32_q[$];
  int win_q[$];

  // Model state: pair slot 0 = not yet aligned, 1 = awaiting first half, 2 = awaiting second.
  int m_pair = 0;
  int m_a    = 0;
  int m_pend_val = 0;
  bit m_prev16 = 1'b1, m_prev32 = 1'b1;
  bit m_pend = 1'b0, m_slot = 1'b0;
  bit m_und = 1'b0, m_ovf = 1'b0, m_und_vis = 1'b0, m_ovf_vis = 1'b0;

  adc_boxcar_decim #(
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_div_16  (clk_div_16),
    .clk_div_32  (clk_div_32),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .dec16_data  (dec16_data),
    .dec16_valid (dec16_valid),
    .dec32_data  (dec32_data),
    .dec32_valid (dec32_valid),
    .dec32_ready (dec32_ready),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int win_avg();
    int s = 0;
    foreach (win_q[i]) s += win_q[i];
    return int'($floor(real'(s) / 16.0 + (RoundEn ? 0.5 : 0.0)));
  endfunction

  function automatic int pair_avg(int a, int b);
    return int'($floor(real'(a + b) / 2.0 + (RoundEn ? 0.5 : 0.0)));
  endfunction

  task automatic emit_window(output int avg);
    avg = win_avg();
    if (win_q.size() < 16) m_und = 1'b1;
    exp16_q.push_back(avg);
  endtask

  // Consequences of the inputs applied in the current cycle.
  task automatic model_cycle();
    bit e16, e32;
    int avg;
    m_und_vis = m_und;
    m_ovf_vis = m_ovf;
    if (rst) begin
      m_pair = 0; m_pend = 1'b0; m_slot = 1'b0; m_und = 1'b0; m_ovf = 1'b0;
      m_prev16 = 1'b1; m_prev32 = 1'b1;
      win_q.delete(); exp16_q.delete(); exp32_q.delete();
      return;
    end
    e16 = clk_div_16 && !m_prev16;
    e32 = clk_div_32 && !m_prev32;
    m_prev16 = clk_div_16;
    m_prev32 = clk_div_32;

    if (m_slot && dec32_ready) m_slot = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      if (!m_slot) begin
        m_slot = 1'b1;
        exp32_q.push_back(m_pend_val);
      end else begin
        m_ovf = 1'b1;
      end
    end

    if (e16) begin
      if (m_pair == 0) begin
        if (e32) m_pair = 1;
      end else if (m_pair == 1) begin
        if (!e32) begin
          emit_window(avg);
          m_a = avg;
          m_pair = 2;
        end
      end else begin
        emit_window(avg);
        if (e32) begin
          m_pend_val = pair_avg(m_a, avg);
          m_pend = 1'b1;
          m_pair = 1;
        end else begin
          m_a = avg;
        end
      end
      win_q.delete();
    end
    if (adc_valid) win_q.push_back(int'($signed(adc_data)));
  endtask

  function automatic int nxt_p();
    return (cyc + 1) % 32;
  endfunction

  task automatic drive(bit r, bit v, int val, bit rdy);
    int p;
    @(posedge clk);
    #1;
    rst = r;
    adc_valid = v;
    adc_data = val[DATA_W-1:0];
    dec32_ready = rdy;
    cyc++;
    p = cyc % 32;
    clk_div_16 = (p % 16) < 8;
    clk_div_32 = p < 16;
    model_cycle();
  endtask

  task automatic reset_pulse(int n, int val);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, val, 1'b1);
    drive(1'b0, 1'b1, val, 1'b1);
    @(negedge clk);
    check("reset dec16_data", int'(dec16_data), 0);
    check("reset dec16_valid", int'(dec16_valid), 0);
    check("reset dec32_data", int'(dec32_data), 0);
    check("reset dec32_valid", int'(dec32_valid), 0);
    check("reset underrun", int'(underrun), 0);
    check("reset overflow", int'(overflow), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (dec16_valid) begin
        if (exp16_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dec16 unexpected: got %0d, expected no output", $signed(dec16_data));
        end else begin
          check("dec16_data", int'($signed(dec16_data)), exp16_q.pop_front());
        end
      end
      if (dec32_valid && dec32_ready) begin
        if (exp32_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dec32 unexpected: got %0d, expected no output", $signed(dec32_data));
        end else begin
          check("dec32_data", int'($signed(dec32_data)), exp32_q.pop_front());
        end
      end
      if ((cyc % 16) == 8) begin
        check("underrun", int'(underrun), int'(m_und_vis));
        check("overflow", int'(overflow), int'(m_ovf_vis));
      end
    end
  end

  initial begin
    rst = 1'b1; adc_valid = 1'b0; adc_data = '0; dec32_ready = 1'b1;
    clk_div_16 = 1'b1; clk_div_32 = 1'b1;
    reset_pulse(3, 0);

    for (int i = 0; i < 96; i++) drive(1'b0, 1'b1, 100, 1'b1);
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, i % 2, 1'b1);
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, (nxt_p() < 16) ? -5 : 7, 1'b1);
    for (int i = 0; i < 64; i++)
      drive(1'b0, !(i < 32 && nxt_p() inside {3, 4, 5}), 64, 1'b1);

    for (int i = 0; i < 320; i++)
      drive(1'b0, $urandom_range(0, 9) != 0, int'($urandom_range(0, 4095)),
            $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, -300, 1'b1);

    for (int i = 0; i < 70; i++) drive(1'b0, 1'b1, 200, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, -41, 1'b1);

    while (nxt_p() != 8) drive(1'b0, 1'b1, 50, 1'b1);
    reset_pulse(2, 50);
    for (int i = 0; i < 96; i++) drive(1'b0, 1'b1, 77, 1'b1);

    while (nxt_p() != 5) drive(1'b0, 1'b1, 77, 1'b1);
    @(negedge clk);
    #1;
    check("dec16 results outstanding", exp16_q.size(), 0);
    check("dec32 results outstanding", exp32_q.size(), 0);
    check("final underrun", int'(underrun), int'(m_und_vis));
    check("final overflow", int'(overflow), int'(m_ovf_vis));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
